// File: rtl/rom_burst_reader.sv
// Burst address sequencer for a 1-cycle registered ROM, with a 2-entry skid
// FIFO that turns the ROM read data into a lossless valid/ready stream.
module rom_burst_reader #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_BITS  = 14,
  parameter int LEN_BITS   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  start_addr,
  input  logic [LEN_BITS-1:0]   start_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_BITS-1:0]  rom_address,
  output logic                  rom_enable,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [LEN_BITS-1:0]   rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic                  fifo_tag_q [2];
  logic                  fifo_tag_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;

  always_comb begin
    pop   = (count_q != 2'd0) & out_ready;
    push  = inflight_q;
    // Slots already committed after this cycle's pop: stored words plus the one in flight.
    occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue = (state_q == S_RUN) && (rem_q != '0) && (occ < 3'd2);

    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    inflight_d      = issue;
    inflight_last_d = issue && (rem_q == LEN_BITS'(1));
    fifo_data_d     = fifo_data_q;
    fifo_tag_d      = fifo_tag_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = start_addr;
          rem_d   = start_len;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_BITS'(1);
          rem_d  = rem_q - LEN_BITS'(1);
        end
        if ((rem_q == '0) && !inflight_q && (count_q == 2'd0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      fifo_data_d[wr_ptr_q] = rom_data;
      fifo_tag_d[wr_ptr_q]  = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_tag_q[0]   <= 1'b0;
      fifo_tag_q[1]   <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_tag_q      <= fifo_tag_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign rom_enable  = issue;
  assign rom_address = addr_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = fifo_data_q[rd_ptr_q];
  assign out_last    = out_valid & fifo_tag_q[rd_ptr_q];

endmodule
